// File: rtl/anabellek.sv
// anabellek: word-addressed main memory companion for islemci.
//   clk         : write clock (rising edge)
//   adres       : byte address; row = (adres - TABAN) >> 2
//   oku_veri    : combinational read data, 0 when adres is out of range
//   yaz_veri    : write data
//   yaz_gecerli : write enable, sampled at the rising edge
module anabellek #(
   parameter logic [31:0] TABAN = 32'h8000_0000
) (
   input  logic        clk,
   input  logic [31:0] adres,
   output logic [31:0] oku_veri,
   input  logic [31:0] yaz_veri,
   input  logic        yaz_gecerli
);

   logic [31:0] bellek [0:1023];
   logic [31:0] ofset;
   logic [9:0]  satir;
   logic        aralikta;
   logic        unused_ofset;

   // Subtracting the base first makes addresses below TABAN wrap high and fall out of range.
   assign ofset        = adres - TABAN;
   assign satir        = ofset[11:2];
   assign aralikta     = (ofset[31:12] == 20'd0);
   assign unused_ofset = ^ofset[1:0];

   assign oku_veri = aralikta ? bellek[satir] : 32'd0;

   always_ff @(posedge clk) begin
      if (yaz_gecerli && aralikta) begin
         bellek[satir] <= yaz_veri;
      end
   end

endmodule

// File: rtl/islemci.sv
// islemci: three-stage, non-pipelined RV32I subset core (lw, sw, addi, add, sub, and, or,
// xor, lui, beq, bne, jal). Each instruction takes GETIR -> COZYAZMACOKU -> YURUTGERIYAZ.
//   clk             : clock, all state updates on the rising edge
//   rst             : synchronous active-low reset
//   bellek_adres    : PC during fetch, rs1+imm during load/store
//   bellek_oku_veri : combinational memory read data
//   bellek_yaz_veri : store data (rs2)
//   bellek_yaz      : store strobe, high only in YURUTGERIYAZ of sw
module islemci #(
   parameter logic [31:0] BELLEK_ADRES = 32'h8000_0000,
   parameter int unsigned ADRES_BIT    = 32,
   parameter int unsigned VERI_BIT     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [ADRES_BIT-1:0] bellek_adres,
   input  logic [VERI_BIT-1:0]  bellek_oku_veri,
   output logic [VERI_BIT-1:0]  bellek_yaz_veri,
   output logic                 bellek_yaz
);

   typedef enum logic [1:0] {
      GETIR        = 2'd0,
      COZYAZMACOKU = 2'd1,
      YURUTGERIYAZ = 2'd2,
      GECERSIZ     = 2'd3
   } asama_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   asama_e      simdiki_asama_r;
   logic [31:0] yazmac_obegi [0:31];
   logic [31:0] pc_r, komut_r, rs1_veri_r, rs2_veri_r, imm_r;
   logic [31:0] bellek_adres_r;
   logic        bellek_yaz_r;

   // Instruction fields
   logic [6:0] opcode, funct7;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] funct3;
   assign opcode = komut_r[6:0];
   assign rd     = komut_r[11:7];
   assign funct3 = komut_r[14:12];
   assign rs1    = komut_r[19:15];
   assign rs2    = komut_r[24:20];
   assign funct7 = komut_r[31:25];

   // Decode-stage values
   logic [31:0] imm_sec, rs1_oku, rs2_oku;
   logic        sw_mi, bellek_erisim;

   assign rs1_oku       = (rs1 == 5'd0) ? 32'd0 : yazmac_obegi[rs1];
   assign rs2_oku       = (rs2 == 5'd0) ? 32'd0 : yazmac_obegi[rs2];
   assign sw_mi         = (opcode == OP_STORE) && (funct3 == 3'b010);
   assign bellek_erisim = sw_mi || ((opcode == OP_LOAD) && (funct3 == 3'b010));

   always_comb begin
      imm_sec = {{20{komut_r[31]}}, komut_r[31:20]};
      case (opcode)
         OP_STORE:  imm_sec = {{20{komut_r[31]}}, komut_r[31:25], komut_r[11:7]};
         OP_BRANCH: imm_sec = {{19{komut_r[31]}}, komut_r[31], komut_r[7], komut_r[30:25],
                               komut_r[11:8], 1'b0};
         OP_LUI:    imm_sec = {komut_r[31:12], 12'd0};
         OP_JAL:    imm_sec = {{11{komut_r[31]}}, komut_r[31], komut_r[19:12], komut_r[20],
                               komut_r[30:21], 1'b0};
         default:   imm_sec = {{20{komut_r[31]}}, komut_r[31:20]};
      endcase
   end

   // Execute-stage result, write enable and next PC
   logic [31:0] sonuc, pc_sonraki;
   logic        yaz_en;

   always_comb begin
      sonuc      = 32'd0;
      yaz_en     = 1'b0;
      pc_sonraki = pc_r + 32'd4;
      case (opcode)
         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               sonuc  = bellek_oku_veri;
               yaz_en = 1'b1;
            end
         end
         OP_IMM: begin
            if (funct3 == 3'b000) begin
               sonuc  = rs1_veri_r + imm_r;
               yaz_en = 1'b1;
            end
         end
         OP_REG: begin
            yaz_en = 1'b1;
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: sonuc = rs1_veri_r + rs2_veri_r;
               {7'b0100000, 3'b000}: sonuc = rs1_veri_r - rs2_veri_r;
               {7'b0000000, 3'b111}: sonuc = rs1_veri_r & rs2_veri_r;
               {7'b0000000, 3'b110}: sonuc = rs1_veri_r | rs2_veri_r;
               {7'b0000000, 3'b100}: sonuc = rs1_veri_r ^ rs2_veri_r;
               default:              yaz_en = 1'b0;
            endcase
         end
         OP_LUI: begin
            sonuc  = imm_r;
            yaz_en = 1'b1;
         end
         OP_BRANCH: begin
            if ((funct3 == 3'b000 && rs1_veri_r == rs2_veri_r) ||
                (funct3 == 3'b001 && rs1_veri_r != rs2_veri_r)) begin
               pc_sonraki = pc_r + imm_r;
            end
         end
         OP_JAL: begin
            sonuc      = pc_r + 32'd4;
            yaz_en     = 1'b1;
            pc_sonraki = pc_r + imm_r;
         end
         default: ;
      endcase
   end

   // The register file sits outside the reset branch on purpose: it is never cleared.
   always_ff @(posedge clk) begin
      if (!rst) begin
         simdiki_asama_r <= GETIR;
         pc_r            <= BELLEK_ADRES;
         komut_r         <= 32'd0;
         bellek_adres_r  <= BELLEK_ADRES;
         bellek_yaz_r    <= 1'b0;
      end else begin
         unique case (simdiki_asama_r)
            GETIR: begin
               komut_r         <= bellek_oku_veri;
               simdiki_asama_r <= COZYAZMACOKU;
            end
            COZYAZMACOKU: begin
               rs1_veri_r <= rs1_oku;
               rs2_veri_r <= rs2_oku;
               imm_r      <= imm_sec;
               if (bellek_erisim) begin
                  bellek_adres_r <= rs1_oku + imm_sec;
               end
               bellek_yaz_r    <= sw_mi;
               simdiki_asama_r <= YURUTGERIYAZ;
            end
            YURUTGERIYAZ: begin
               if (yaz_en && rd != 5'd0) begin
                  yazmac_obegi[rd] <= sonuc;
               end
               pc_r            <= pc_sonraki;
               bellek_adres_r  <= pc_sonraki;
               bellek_yaz_r    <= 1'b0;
               simdiki_asama_r <= GETIR;
            end
            default: begin
               bellek_adres_r  <= pc_r;
               bellek_yaz_r    <= 1'b0;
               simdiki_asama_r <= GETIR;
            end
         endcase
      end
   end

   assign bellek_adres    = bellek_adres_r;
   assign bellek_yaz_veri = rs2_veri_r;
   // Gate with rst so a reset landing in a store cycle suppresses the write at that edge.
   assign bellek_yaz      = bellek_yaz_r & rst;

endmodule

// File: tb/tb_islemci.sv
module tb_islemci;

   localparam logic [31:0] TABAN = 32'h8000_0000;

   logic        clk, rst;
   logic [31:0] bellek_adres, bellek_yaz_veri, oku_veri;
   logic        bellek_yaz;

   // While yukle is high the bench owns the memory port (program/data loading and readback).
   logic        yukle, tb_yaz;
   logic [31:0] tb_adres, tb_veri;

   islemci #(.BELLEK_ADRES(TABAN)) dut (
      .clk            (clk),
      .rst            (rst),
      .bellek_adres   (bellek_adres),
      .bellek_oku_veri(oku_veri),
      .bellek_yaz_veri(bellek_yaz_veri),
      .bellek_yaz     (bellek_yaz)
   );

   anabellek #(.TABAN(TABAN)) u_bellek (
      .clk        (clk),
      .adres      (yukle ? tb_adres : bellek_adres),
      .oku_veri   (oku_veri),
      .yaz_veri   (yukle ? tb_veri : bellek_yaz_veri),
      .yaz_gecerli(yukle ? tb_yaz : bellek_yaz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_kontrol = 0;
   int n_hata    = 0;

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                          input logic [31:0] beklenen);
      n_kontrol++;
      if (gozlenen !== beklenen) begin
         n_hata++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
      end
   endtask

   // Scoreboard
   typedef struct {
      bit          bellek;
      logic [31:0] yer;
      logic [31:0] deger;
   } beklenen_t;
   beklenen_t sb[$];

   task automatic push_reg(input int idx, input logic [31:0] d);
      beklenen_t e;
      e.bellek = 1'b0; e.yer = 32'(idx); e.deger = d;
      sb.push_back(e);
   endtask

   task automatic push_mem(input logic [31:0] a, input logic [31:0] d);
      beklenen_t e;
      e.bellek = 1'b1; e.yer = a; e.deger = d;
      sb.push_back(e);
   endtask

   task automatic mem_yaz(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      tb_adres = a; tb_veri = d; tb_yaz = 1'b1;
      @(negedge clk);
      tb_yaz = 1'b0;
   endtask

   task automatic mem_oku(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      tb_adres = a;
      #1 d = oku_veri;
   endtask

   task automatic sb_bosalt();
      beklenen_t   e;
      logic [31:0] d;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.bellek) begin
            mem_oku(e.yer, d);
            kontrol($sformatf("mem[%08h]", e.yer), d, e.deger);
         end else begin
            kontrol($sformatf("x%0d", e.yer), dut.yazmac_obegi[e.yer[4:0]], e.deger);
         end
      end
   endtask

   // Program builder
   logic [31:0] prog[$];

   function automatic logic [31:0] sonraki_pc();
      return TABAN + 32'(4 * prog.size());
   endfunction

   task automatic emit(input logic [31:0] k);
      prog.push_back(k);
   endtask

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3,
                                         logic [4:0] rdx, logic [6:0] op);
      return {imm, r1, f3, rdx, op};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                         logic [2:0] f3, logic [4:0] rdx);
      return {f7, r2, r1, f3, rdx, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] r2, logic [4:0] r1);
      return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] r2, logic [4:0] r1,
                                         logic [2:0] f3);
      return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rdx);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rdx, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_lw(logic [11:0] off, logic [4:0] r1, logic [4:0] rdx);
      return enc_i(off, r1, 3'b010, rdx, 7'b0000011);
   endfunction

   // lui + addi pair; the +0x800 compensates for addi sign-extending its low 12 bits.
   task automatic emit_li(input int rdi, input logic [31:0] v);
      logic [31:0] ust;
      ust = (v + 32'h800) >> 12;
      emit({ust[19:0], 5'(rdi), 7'b0110111});
      emit(enc_i(v[11:0], 5'(rdi), 3'b000, 5'(rdi), 7'b0010011));
   endtask

   task automatic program_yukle();
      for (int i = 0; i < prog.size(); i++) mem_yaz(TABAN + 32'(4 * i), prog[i]);
   endtask

   logic [31:0] pozveri [5] = '{32'h200, 32'h400, 32'h800, 32'hC00, 32'h1000};
   logic [31:0] negveri [5] = '{32'h2000, 32'h4000, 32'h8000, 32'hC000, 32'h10000};
   logic [31:0] sdeger  [5] = '{32'hFF00_3301, 32'h1111_1111, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'h0000_0ABC};
   logic [31:0] ndeger  [5] = '{32'h00DB_DBDB, 32'h1234_5678, 32'hCAFE_F00D, 32'h0000_0000,
                                32'h00DD_DDDD};

   initial begin
      logic [31:0] a, b, d, pc_jal;
      int          n_komut;

      rst = 1'b0; yukle = 1'b1; tb_yaz = 1'b0; tb_adres = 32'd0; tb_veri = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      kontrol("rst_adres", bellek_adres, TABAN);
      kontrol("rst_asama", {30'd0, dut.simdiki_asama_r}, 32'd0);
      kontrol("rst_yaz", {31'd0, bellek_yaz}, 32'd0);
      kontrol("rst_komut", dut.komut_r, 32'd0);

      // Program A: loads, stores, ALU, branches, jal, x0, NOPs
      emit_li(4, 32'h8000_0200);
      push_reg(4, 32'h8000_0200);
      emit_li(20, 32'hFFFF_FFFF);
      for (int k = 0; k < 5; k++) begin
         emit(enc_lw(12'(4 * k), 5'd4, 5'(20 + k)));
         push_reg(20 + k, pozveri[k]);
      end
      emit_li(5, 32'h8000_0224);
      for (int k = 0; k < 5; k++) begin
         emit(enc_lw(12'(-4 * k), 5'd5, 5'(25 + k)));
         push_reg(25 + k, negveri[k]);
      end
      emit_li(6, 32'h8000_0300);
      for (int k = 0; k < 5; k++) emit_li(8 + k, sdeger[k]);
      for (int k = 0; k < 5; k++) begin
         emit(enc_s(12'(4 * k), 5'(8 + k), 5'd6));
         push_mem(32'h8000_0300 + 32'(4 * k), sdeger[k]);
      end
      emit_li(7, 32'h8000_0410);
      for (int k = 0; k < 5; k++) emit_li(13 + k, ndeger[k]);
      for (int k = 0; k < 5; k++) begin
         emit(enc_s(12'(-4 * k), 5'(13 + k), 5'd7));
         push_mem(32'h8000_0410 - 32'(4 * k), ndeger[k]);
      end
      a = 32'h0F0F_1234; b = 32'h00FF_00FF;
      emit_li(18, a);
      emit_li(19, b);
      emit(enc_r(7'b0000000, 5'd19, 5'd18, 3'b000, 5'd2));  push_reg(2, a + b);
      emit(enc_r(7'b0100000, 5'd18, 5'd19, 3'b000, 5'd3));  push_reg(3, b - a);
      emit(enc_r(7'b0000000, 5'd19, 5'd18, 3'b111, 5'd30)); push_reg(30, a & b);
      emit(enc_r(7'b0000000, 5'd19, 5'd18, 3'b110, 5'd31));
      emit(enc_r(7'b0000000, 5'd19, 5'd18, 3'b100, 5'd18)); push_reg(18, a ^ b);
      emit(enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011));     // addi x0, x0, 5
      emit(enc_s(12'h180, 5'd0, 5'd6));                         // sw x0 -> 0x8000_0480
      push_mem(32'h8000_0480, 32'd0);
      emit(enc_b(13'd8, 5'd3, 5'd2, 3'b001));                   // bne taken
      emit(enc_i(12'd7, 5'd0, 3'b000, 5'd20, 7'b0010011));    // skipped
      emit(enc_b(13'd8, 5'd3, 5'd2, 3'b000));                   // beq not taken
      emit(enc_i(12'd1, 5'd31, 3'b000, 5'd31, 7'b0010011));
      push_reg(31, (a | b) + 32'd1);
      pc_jal = sonraki_pc();
      emit(enc_j(21'd8, 5'd1));
      push_reg(1, pc_jal + 32'd4);
      emit(enc_i(12'd7, 5'd0, 3'b000, 5'd21, 7'b0010011));    // skipped
      emit(32'h0000_0000);                                      // unknown opcode -> NOP
      emit(32'hFFFF_FFFF);                                      // unknown opcode -> NOP
      emit(enc_j(21'd0, 5'd0));                                 // park here
      n_komut = prog.size();

      program_yukle();
      for (int k = 0; k < 5; k++) begin
         mem_yaz(32'h8000_0200 + 32'(4 * k), pozveri[k]);
         mem_yaz(32'h8000_0224 - 32'(4 * k), negveri[k]);
      end
      mem_yaz(32'h8000_0480, 32'hFFFF_FFFF);

      // Out-of-range accesses
      mem_oku(32'h9000_0000, d);
      kontrol("oor_oku_ust", d, 32'd0);
      mem_oku(32'h7FFF_FFFC, d);
      kontrol("oor_oku_alt", d, 32'd0);
      mem_yaz(32'h8000_1000, 32'h0000_0BAD);
      mem_oku(TABAN, d);
      kontrol("oor_yaz", d, prog[0]);

      @(negedge clk);
      yukle = 1'b0; rst = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #2 kontrol("asama", {30'd0, dut.simdiki_asama_r}, 32'((i + 1) % 3));
      end
      repeat (3 * n_komut + 30) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 yukle = 1'b1;
      sb_bosalt();

      // Program B: one sw to 0x8000_0500, aborted by reset in its execute cycle
      prog.delete();
      emit(enc_s(12'h200, 5'd8, 5'd6));
      program_yukle();
      mem_yaz(32'h8000_0500, 32'd0);
      push_mem(32'h8000_0500, 32'd0);

      @(negedge clk);
      rst = 1'b1; yukle = 1'b0;
      #1;
      kontrol("yeniden_asama", {30'd0, dut.simdiki_asama_r}, 32'd0);
      kontrol("yeniden_adres", bellek_adres, TABAN);
      @(posedge clk);
      #1 kontrol("b_komut", dut.komut_r, prog[0]);
      @(posedge clk);
      #1;
      kontrol("b_asama", {30'd0, dut.simdiki_asama_r}, 32'd2);
      kontrol("b_yaz", {31'd0, bellek_yaz}, 32'd1);
      kontrol("b_adres", bellek_adres, 32'h8000_0500);
      kontrol("b_veri", bellek_yaz_veri, sdeger[0]);
      rst = 1'b0;
      #1 kontrol("b_yaz_rst", {31'd0, bellek_yaz}, 32'd0);
      @(posedge clk);
      #1;
      kontrol("abort_asama", {30'd0, dut.simdiki_asama_r}, 32'd0);
      kontrol("abort_adres", bellek_adres, TABAN);
      yukle = 1'b1;
      sb_bosalt();

      // Fetch restarts from the reset PC
      @(negedge clk);
      rst = 1'b1; yukle = 1'b0;
      @(posedge clk);
      #1;
      kontrol("tekrar_asama", {30'd0, dut.simdiki_asama_r}, 32'd1);
      kontrol("tekrar_komut", dut.komut_r, prog[0]);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_hata, n_kontrol);
      $finish;
   end

endmodule

// File: doc/islemci.md
ISLEMCI -- requirements
Module: islemci

Interface
REQ-001 Parameter BELLEK_ADRES, default 32'h8000_0000, meaning: reset PC and base address of the companion memory anabellek.
REQ-002 Parameter ADRES_BIT, default 32, meaning: address width.
REQ-003 Parameter VERI_BIT, default 32, meaning: data and instruction width.
REQ-004 Port clk, input, 1, meaning: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, meaning: synchronous, active-low reset.
REQ-006 Port bellek_adres, output, 32, meaning: memory address (PC during fetch, rs1+imm during load/store).
REQ-007 Port bellek_oku_veri, input, 32, meaning: combinational memory read data.
REQ-008 Port bellek_yaz_veri, output, 32, meaning: store data (rs2).
REQ-009 Port bellek_yaz, output, 1, meaning: memory write strobe, one cycle per store.

Function
REQ-010 Three-state FSM register simdiki_asama_r[1:0] SHALL be exposed by hierarchical name, with localparams GETIR=0, COZYAZMACOKU=1 and YURUTGERIYAZ=2.
REQ-011 Sequence SHALL be GETIR -> COZYAZMACOKU -> YURUTGERIYAZ -> GETIR, every instruction taking exactly 3 cycles, with no stalls.
REQ-012 Encoding 3 SHALL be unreachable and SHALL return to GETIR on the next edge.
REQ-013 GETIR: bellek_adres=PC; the instruction register SHALL latch bellek_oku_veri at the edge.
REQ-014 COZYAZMACOKU: decode; latch rs1 value, rs2 value and sign-extended immediate.
REQ-015 YURUTGERIYAZ: execute, perform the memory access, write back rd and update PC at the edge.
REQ-016 Register file yazmac_obegi[0:31], 32 bits each, SHALL be reachable by hierarchical name and be writable by the bench at any time.
REQ-017 Reads of x0 SHALL return 0; writes to x0 SHALL be discarded.
REQ-018 Supported instruction lw: rd = mem[rs1 + sext(imm[11:0])].
REQ-019 Supported instruction sw: mem[rs1 + sext(imm)] = rs2, with imm = {inst[31:25], inst[11:7]}.
REQ-020 Supported instructions addi, add, sub, and, or, xor, and lui.
REQ-021 Supported instructions beq and bne: PC+sext(B-imm) if taken, else PC+4.
REQ-022 Supported instruction jal: rd = PC+4; PC += sext(J-imm).
REQ-023 Address and ALU arithmetic SHALL be 32-bit two's-complement with wrap-around; negative offsets (e.g. -16) SHALL subtract.
REQ-024 Any other opcode SHALL execute as a NOP (PC+4, no register or memory write).
REQ-025 bellek_yaz SHALL be 1 only in the YURUTGERIYAZ cycle of sw; it SHALL be 0 at all other times, including in reset.
REQ-026 The load result SHALL be taken from bellek_oku_veri within the same YURUTGERIYAZ cycle; the memory read is combinational.
REQ-027 Companion module anabellek SHALL have ports clk; adres[31:0]; oku_veri[31:0] out; yaz_veri[31:0]; yaz_gecerli.
REQ-028 anabellek SHALL hold word array bellek[0:1023], with row index = (adres - 0x8000_0000) >> 2.
REQ-029 anabellek oku_veri SHALL be combinational.
REQ-030 anabellek SHALL perform its write at the rising edge when yaz_gecerli=1.
REQ-031 anabellek out-of-range reads SHALL return 0; out-of-range writes SHALL be ignored.

Reset
REQ-032 While rst=0 at an edge: PC=BELLEK_ADRES, simdiki_asama_r=GETIR, instruction register=0, bellek_yaz=0.
REQ-033 The register file SHALL NOT be cleared by reset; its initial value is don't-care.
REQ-034 Reset asserted mid-instruction SHALL abort that instruction: no register write-back, no memory write.
REQ-035 At the first edge after rst returns to 1, simdiki_asama_r SHALL still read GETIR with PC=0x8000_0000, and the first fetch SHALL then proceed.

Verification
REQ-036 Stage check: over 20 instructions, sample 2 ns after each edge -> GETIR, COZYAZMACOKU, YURUTGERIYAZ repeating with no deviation.
REQ-037 Positive-offset loads: x4=0x8000_0200; memory 0x200..0x210 holds 0x200, 0x400, 0x800, 0xC00, 0x1000; lw x20..x24 with offsets 0..16 -> x20=0x200 (overwriting 0xFFFF_FFFF), x21=0x400, x22=0x800, x23=0xC00, x24=0x1000.
REQ-038 Negative-offset loads: x5=0x8000_0224; lw x25..x29 with offsets 0, -4, -8, -12, -16 -> x25..x29 = 0x2000, 0x4000, 0x8000, 0xC000, 0x10000.
REQ-039 Positive-offset stores: x6=0x8000_0300; sw x8..x12 with offsets 0..16 -> mem[0x8000_0300 + 4k] equals x(8+k), including negative values such as -0xFFCCFF.
REQ-040 Negative-offset stores: x7=0x8000_0410; sw x13..x17 with offsets 0..-16 -> mem[0x8000_0410 - 4k] equals x(13+k), e.g. 0x410 = 0xDBDBDB and 0x400 = 0xDDDDDD.
REQ-041 x0 and reset cases: addi x0, x0, 5 -> x0 remains 0; rst=0 during YURUTGERIYAZ of a sw -> memory unchanged, restart fetch at 0x8000_0000.
